program_loader: RTL and testbench

Boot-time writer for the CPU's instruction-memory load port. Accepts a byte stream over a valid/ready handshake and parses a framed image: a 16-bit halfword count, the halfwords, and an XOR checksum. Drives `program_mem_write_en`, `instruction` and `instruction_addr` into `arm_cpu` and holds the CPU in reset until a clean image has loaded. Sits between the host byte source (UART receiver or testbench) and the CPU top.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared widths, limits and state encoding for the instruction-memory loader.
`timescale 1ns/1ps
package program_loader_pkg;

    localparam int unsigned HALF_WORD         = 16;
    localparam int unsigned WORD              = 32;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned MAX_HALFWORDS_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Boot loader: parses a length/halfwords/XOR-checksum byte frame and writes the
// halfwords into the CPU instruction memory, holding the CPU in reset until done.
`timescale 1ns/1ps
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR     = '0,
    parameter int unsigned     MAX_HALFWORDS = MAX_HALFWORDS_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [BYTE_W-1:0]     byte_i,
    output logic                  byte_ready_o,
    output logic                  program_mem_write_en_o,
    output logic [HALF_WORD-1:0]  instruction_o,
    output logic [WORD-1:0]       instruction_addr_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           loaded_count_o
);

    loader_state_e      state;
    logic [BYTE_W-1:0]  lo_byte;
    logic [BYTE_W-1:0]  checksum;
    logic [15:0]        remaining;
    logic               accept;
    logic [15:0]        len_word;

    assign accept   = byte_valid_i & byte_ready_o;
    assign len_word = {byte_i, lo_byte};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state                  <= S_IDLE;
            lo_byte                <= '0;
            checksum               <= '0;
            remaining              <= '0;
            byte_ready_o           <= 1'b0;
            program_mem_write_en_o <= 1'b0;
            instruction_o          <= '0;
            instruction_addr_o     <= BASE_ADDR;
            cpu_reset_o            <= 1'b1;
            done_o                 <= 1'b0;
            error_o                <= 1'b0;
            loaded_count_o         <= '0;
        end else begin
            program_mem_write_en_o <= 1'b0;
            // Address moves on the edge that ends the strobe cycle.
            if (program_mem_write_en_o) begin
                instruction_addr_o <= instruction_addr_o + WORD'(2);
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state              <= S_LEN_LO;
                        checksum           <= '0;
                        loaded_count_o     <= '0;
                        instruction_addr_o <= BASE_ADDR;
                        done_o             <= 1'b0;
                        error_o            <= 1'b0;
                        cpu_reset_o        <= 1'b1;
                        byte_ready_o       <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        lo_byte  <= byte_i;
                        checksum <= checksum ^ byte_i;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        checksum  <= checksum ^ byte_i;
                        remaining <= len_word;
                        if (32'(len_word) > MAX_HALFWORDS) begin
                            state        <= S_ERROR;
                            error_o      <= 1'b1;
                            byte_ready_o <= 1'b0;
                        end else if (len_word == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_LO;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        lo_byte  <= byte_i;
                        checksum <= checksum ^ byte_i;
                        state    <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        checksum               <= checksum ^ byte_i;
                        program_mem_write_en_o <= 1'b1;
                        instruction_o          <= {byte_i, lo_byte};
                        loaded_count_o         <= loaded_count_o + 16'(1);
                        remaining              <= remaining - 16'(1);
                        state                  <= (remaining == 16'd1) ? S_CHECK : S_DATA_LO;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        byte_ready_o <= 1'b0;
                        if (byte_i == checksum) begin
                            state       <= S_DONE;
                            done_o      <= 1'b1;
                            cpu_reset_o <= 1'b0;
                        end else begin
                            state   <= S_ERROR;
                            error_o <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench for program_loader against a frame-level reference model.
`timescale 1ns/1ps
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int unsigned MAXH = 256;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        program_mem_write_en_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] loaded_count_o;

    program_loader #(.BASE_ADDR(32'h0), .MAX_HALFWORDS(MAXH)) dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .start_i                (start_i),
        .byte_valid_i           (byte_valid_i),
        .byte_i                 (byte_i),
        .byte_ready_o           (byte_ready_o),
        .program_mem_write_en_o (program_mem_write_en_o),
        .instruction_o          (instruction_o),
        .instruction_addr_o     (instruction_addr_o),
        .cpu_reset_o            (cpu_reset_o),
        .done_o                 (done_o),
        .error_o                (error_o),
        .loaded_count_o         (loaded_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;
    typedef logic [7:0] byteq_t[$];
    typedef wr_t        wrq_t[$];

    int   total = 0;
    int   bad   = 0;
    int   wide  = 0;
    logic prev_we = 1'b0;
    wrq_t obs_q;

    // Capture every write strobe and flag any strobe held two cycles in a row.
    always @(negedge clk_i) begin
        if (program_mem_write_en_o) begin
            obs_q.push_back('{addr: instruction_addr_o, data: instruction_o});
            if (prev_we) wide++;
        end
        prev_we = program_mem_write_en_o;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame semantics: N halfwords at consecutive even addresses, XOR over all prior bytes.
    task automatic model(input byteq_t f, output wrq_t w, output bit ok, output int acc);
        int n;
        logic [7:0] x;
        w   = {};
        n   = int'({f[1], f[0]});
        x   = 8'h00;
        ok  = 1'b0;
        acc = 2;
        if (n > int'(MAXH)) return;
        for (int k = 0; k < n; k++)
            w.push_back('{addr: 32'(2 * k), data: {f[3 + 2 * k], f[2 + 2 * k]}});
        for (int i = 0; i < 2 + 2 * n; i++) x = x ^ f[i];
        ok  = (f[2 + 2 * n] == x);
        acc = 3 + 2 * n;
    endtask

    task automatic send(input byteq_t f, input bit gaps, input int start_at, output int acc);
        int idx;
        int budget;
        idx    = 0;
        budget = 4 * f.size() + 30;
        for (int c = 0; c < budget && idx < f.size(); c++) begin
            @(negedge clk_i);
            start_i      = (start_at >= 0 && idx == start_at);
            byte_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            byte_i       = f[idx];
            if (byte_valid_i && byte_ready_o) idx++;
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        acc          = idx;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, "_st_ready"}, 64'(byte_ready_o), 64'(1));
        check({tag, "_st_done"},  64'(done_o),       64'(0));
        check({tag, "_st_err"},   64'(error_o),      64'(0));
        check({tag, "_st_rst"},   64'(cpu_reset_o),  64'(1));
        check({tag, "_st_cnt"},   64'(loaded_count_o), 64'(0));
    endtask

    task automatic run_frame(input string tag, input byteq_t f, input bit gaps, input int start_at);
        wrq_t ew;
        bit   ok;
        int   eacc;
        int   acc;
        int   m;
        model(f, ew, ok, eacc);
        obs_q = {};
        pulse_start(tag);
        send(f, gaps, start_at, acc);
        @(negedge clk_i);
        @(negedge clk_i);
        check({tag, "_accepted"}, 64'(acc), 64'(eacc));
        check({tag, "_nwrites"},  64'(obs_q.size()), 64'(ew.size()));
        m = (obs_q.size() < ew.size()) ? obs_q.size() : ew.size();
        for (int k = 0; k < m; k++) begin
            check($sformatf("%s_wr%0d_addr", tag, k), 64'(obs_q[k].addr), 64'(ew[k].addr));
            check($sformatf("%s_wr%0d_data", tag, k), 64'(obs_q[k].data), 64'(ew[k].data));
        end
        check({tag, "_done"},  64'(done_o),         64'(ok));
        check({tag, "_error"}, 64'(error_o),        64'(!ok));
        check({tag, "_cpurst"},64'(cpu_reset_o),    64'(!ok));
        check({tag, "_ready"}, 64'(byte_ready_o),   64'(0));
        check({tag, "_count"}, 64'(loaded_count_o), 64'(ew.size()));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(byte_ready_o),           64'(0));
        check({tag, "_we"},    64'(program_mem_write_en_o), 64'(0));
        check({tag, "_instr"}, 64'(instruction_o),          64'(0));
        check({tag, "_addr"},  64'(instruction_addr_o),     64'(0));
        check({tag, "_cpurst"},64'(cpu_reset_o),            64'(1));
        check({tag, "_done"},  64'(done_o),                 64'(0));
        check({tag, "_error"}, 64'(error_o),                64'(0));
        check({tag, "_count"}, 64'(loaded_count_o),         64'(0));
    endtask

    initial begin
        byteq_t f;
        byteq_t g;
        int     acc;
        int     n;
        logic [7:0] x;
        logic [7:0] b;

        reset_i      = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(negedge clk_i);
        check_reset_vals("reset");
        reset_i = 1'b0;

        // Bytes offered while idle must not be taken.
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_i       = 8'h55;
        @(negedge clk_i);
        check("idle_ready", 64'(byte_ready_o), 64'(0));
        byte_valid_i = 1'b0;

        f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        run_frame("good2", f, 1'b0, -1);

        f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
        run_frame("badchk", f, 1'b0, -1);

        f = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", f, 1'b0, -1);

        f = '{8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        run_frame("toolong", f, 1'b0, -1);

        f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        run_frame("gaps", f, 1'b1, 3);

        // Largest legal image.
        g = '{8'h00, 8'h01};
        x = 8'h01;
        for (int i = 0; i < 512; i++) begin
            b = 8'($urandom);
            g.push_back(b);
            x = x ^ b;
        end
        g.push_back(x);
        run_frame("max256", g, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            g = '{8'(n), 8'h00};
            x = 8'(n);
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom);
                g.push_back(b);
                x = x ^ b;
            end
            if (r % 2 == 1) x = x ^ 8'($urandom_range(1, 255));
            g.push_back(x);
            run_frame($sformatf("rand%0d", r), g, 1'b1, (r == 2) ? 2 : -1);
        end

        // Asynchronous reset after the first strobe, then a clean reload.
        obs_q = {};
        pulse_start("midrst");
        f = '{8'h02, 8'h00, 8'h34, 8'h12};
        send(f, 1'b0, -1, acc);
        @(negedge clk_i);
        check("midrst_first_strobe", 64'(obs_q.size()), 64'(1));
        #2 reset_i = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk_i);
        reset_i = 1'b0;
        f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        run_frame("reload", f, 1'b1, -1);

        check("strobe_width", 64'(wide), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
